rr_arb_8t1_32: RTL and testbench

//   Round-robin arbiter and sequencer that shares one 32-bit result bus between 8 requesters.
//   It generates the 3-bit select for an internal mux_8t1_32 instance and registers the winner's word.
//   The registered word goes out through a valid/ready output stage.

---
 rtl/rr_arb_8t1_32_if.sv | 26 ++
 rtl/rr_arb_8t1_32.sv | 78 +++++++
 tb/tb_rr_arb_8t1_32.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arb_8t1_32_if.sv
// Bundle of the requester side and the result side of the round-robin arbiter.
// Valid/ready rule: a word moves only in a cycle where valid and ready are both 1.
// Valid never waits on ready. A source keeps its word stable until that transfer happens.
`timescale 1ns/1ps
interface rr_arb_8t1_32_if #(
  parameter int WIDTH = 32
);
  logic [7:0]         req_valid;
  logic [8*WIDTH-1:0] req_data;
  logic [7:0]         req_ready;
  logic [2:0]         sel;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_src;
  logic               out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, sel, out_valid, out_data, out_src
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, sel, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_arb_8t1_32.sv
// Round-robin arbiter: eight 32-bit requesters share one registered result port.
// The winner's word goes through an 8:1 mux into a single-entry valid/ready output stage.
`timescale 1ns/1ps
module mux_8t1_32 (
  input  logic [255:0] din,
  input  logic [2:0]   sel,
  output logic [31:0]  dout
);
  assign dout = din[32*sel +: 32];
endmodule

module rr_arb_8t1_32 #(
  parameter int          WIDTH    = 32,
  parameter logic [2:0]  PTR_INIT = 3'd0
) (
  input logic             clk,
  input logic             rst,
  rr_arb_8t1_32_if.slave  bus
);
  logic [2:0]       ptr;
  logic [2:0]       winner;
  logic             found;
  logic             any_req;
  logic             load;
  logic             grant;
  logic [2:0]       sel_c;
  logic [WIDTH-1:0] mux_out;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [2:0]       out_src_q;

  assign any_req = |bus.req_valid;
  assign load    = !out_valid_q || bus.out_ready;
  // While rst is asserted no transfer may be offered even though load is 1.
  assign grant   = load && any_req && !rst;

  // Rotating priority search that starts at ptr.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    for (int k = 0; k < 8; k++) begin
      if (!found && bus.req_valid[ptr + 3'(k)]) begin
        found  = 1'b1;
        winner = ptr + 3'(k);
      end
    end
  end

  assign sel_c = (any_req && !rst) ? winner : ptr;

  mux_8t1_32 u_mux (
    .din  (bus.req_data),
    .sel  (sel_c),
    .dout (mux_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= PTR_INIT;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 3'd0;
    end else if (grant) begin
      ptr         <= winner + 3'd1;
      out_valid_q <= 1'b1;
      out_data_q  <= mux_out;
      out_src_q   <= winner;
    end else if (load) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = grant ? (8'd1 << winner) : 8'd0;
  assign bus.sel       = sel_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_rr_arb_8t1_32.sv
// Self-checking bench for rr_arb_8t1_32: directed scenarios plus a randomized run against a scoreboard.
`timescale 1ns/1ps
module tb_rr_arb_8t1_32;
  logic clk;
  logic rst;
  rr_arb_8t1_32_if #(.WIDTH(32)) bus ();

  rr_arb_8t1_32 #(.WIDTH(32), .PTR_INIT(3'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [34:0]  exp_q[$];
  logic [2:0]   m_ptr;
  logic         m_ov;
  logic [7:0]   cur_rv;
  logic [255:0] cur_rd;
  logic         cur_ordy;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers
  task automatic drive(input logic [7:0] rv, input logic [255:0] rd, input logic ordy);
    cur_rv = rv; cur_rd = rd; cur_ordy = ordy;
    bus.req_valid = rv; bus.req_data = rd; bus.out_ready = ordy;
    #1;
  endtask

  // Reference model + scoreboard for one clock cycle, then advance past the edge.
  task automatic tick();
    logic       load, any, fnd;
    logic [2:0] win, idx;
    logic [7:0] exp_rr;
    logic [2:0] exp_sel;
    logic [34:0] front;
    load = !m_ov || cur_ordy;
    any  = |cur_rv;
    fnd  = 1'b0;
    win  = m_ptr;
    for (int k = 0; k < 8; k++) begin
      idx = m_ptr + 3'(k);
      if (!fnd && cur_rv[idx]) begin fnd = 1'b1; win = idx; end
    end
    exp_rr  = (load && any) ? (8'd1 << win) : 8'd0;
    exp_sel = any ? win : m_ptr;
    checks++;
    if (bus.req_ready !== exp_rr) begin
      errors++; $display("FAIL sb_req_ready: got %h exp %h", bus.req_ready, exp_rr);
    end
    checks++;
    if (bus.sel !== exp_sel) begin
      errors++; $display("FAIL sb_sel: got %0d exp %0d", bus.sel, exp_sel);
    end
    checks++;
    if (bus.out_valid !== m_ov) begin
      errors++; $display("FAIL sb_out_valid: got %b exp %b", bus.out_valid, m_ov);
    end
    if (m_ov && cur_ordy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_underflow: got word %h exp none", bus.out_data);
      end else begin
        front = exp_q.pop_front();
        if ({bus.out_src, bus.out_data} !== front) begin
          errors++;
          $display("FAIL sb_word: got src %0d data %h exp src %0d data %h",
                   bus.out_src, bus.out_data, front[34:32], front[31:0]);
        end
      end
    end
    if (load && any) begin
      exp_q.push_back({win, cur_rd[32*win +: 32]});
      m_ptr = win + 3'd1;
      m_ov  = 1'b1;
    end else if (load) begin
      m_ov = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(8'h00, '0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 3'd0; m_ov = 1'b0; exp_q.delete();
  endtask

  function automatic logic [255:0] seq_data(input logic [31:0] base);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = base + 32'(i);
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(8'hFF, seq_data(32'h1000_0000), 1'b1);
    checks++;
    if (bus.req_ready !== 8'h00 || bus.out_valid !== 1'b0 || bus.sel !== 3'd0) begin
      errors++; $display("FAIL reset_idle: got rr %h ov %b sel %0d exp 00 0 0",
                         bus.req_ready, bus.out_valid, bus.sel);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 3'd0; m_ov = 1'b0; exp_q.delete();
    // build up a word and a non-zero pointer, then reset mid-stream
    drive(8'h20, seq_data(32'hA000_0000), 1'b1);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_src !== 3'd0 ||
        bus.req_ready !== 8'h00) begin
      errors++; $display("FAIL reset_async: got ov %b data %h src %0d rr %h exp 0 0 0 00",
                         bus.out_valid, bus.out_data, bus.out_src, bus.req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 3'd0; m_ov = 1'b0; exp_q.delete();
    drive(8'h41, seq_data(32'hB000_0000), 1'b1);
    checks++;
    if (bus.req_ready !== 8'h01) begin
      errors++; $display("FAIL reset_ptr_init: got %h exp 01", bus.req_ready);
    end
    tick();
    drive(8'h00, '0, 1'b1);
    tick();
  endtask

  task automatic test_single();
    logic [255:0] d;
    d = '0;
    d[64 +: 32] = 32'hDEAD_BEEF;
    drive(8'h04, d, 1'b1);
    checks++;
    if (bus.req_ready !== 8'h04 || bus.sel !== 3'd2) begin
      errors++; $display("FAIL single_grant: got rr %h sel %0d exp 04 2", bus.req_ready, bus.sel);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hDEAD_BEEF || bus.out_src !== 3'd2) begin
      errors++; $display("FAIL single_out: got ov %b data %h src %0d exp 1 deadbeef 2",
                         bus.out_valid, bus.out_data, bus.out_src);
    end
    drive(8'h00, '0, 1'b1);
    checks++;
    if (bus.sel !== 3'd3) begin
      errors++; $display("FAIL single_ptr: got %0d exp 3", bus.sel);
    end
    tick();
  endtask

  task automatic test_all_requesting();
    logic [2:0] exp_src;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      drive(8'hFF, seq_data(32'h1000_0000), 1'b1);
      tick();
      exp_src = 3'(c);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_src !== exp_src ||
          bus.out_data !== 32'h1000_0000 + 32'(exp_src)) begin
        errors++; $display("FAIL all_seq[%0d]: got ov %b src %0d data %h exp 1 %0d %h", c,
                           bus.out_valid, bus.out_src, bus.out_data, exp_src,
                           32'h1000_0000 + 32'(exp_src));
      end
    end
    drive(8'h00, '0, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    drive(8'hFF, seq_data(32'h2000_0000), 1'b1);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(8'hFF, seq_data(32'h2000_0000), 1'b0);
      checks++;
      if (bus.req_ready !== 8'h00 || bus.out_data !== 32'h2000_0000 || bus.out_src !== 3'd0) begin
        errors++; $display("FAIL stall[%0d]: got rr %h data %h src %0d exp 00 20000000 0", c,
                           bus.req_ready, bus.out_data, bus.out_src);
      end
      tick();
    end
    drive(8'hFF, seq_data(32'h2000_0000), 1'b1);
    checks++;
    if (bus.req_ready !== 8'h02) begin
      errors++; $display("FAIL stall_release: got %h exp 02", bus.req_ready);
    end
    tick();
    drive(8'h00, '0, 1'b1);
    tick();
  endtask

  task automatic test_wrap();
    drive(8'h40, seq_data(32'h3000_0000), 1'b1);
    tick();
    drive(8'h81, seq_data(32'h3000_0000), 1'b1);
    checks++;
    if (bus.req_ready !== 8'h80) begin
      errors++; $display("FAIL wrap_first: got %h exp 80", bus.req_ready);
    end
    tick();
    drive(8'h81, seq_data(32'h3000_0000), 1'b1);
    checks++;
    if (bus.req_ready !== 8'h01) begin
      errors++; $display("FAIL wrap_second: got %h exp 01", bus.req_ready);
    end
    tick();
    drive(8'h00, '0, 1'b1);
    checks++;
    if (bus.sel !== 3'd1) begin
      errors++; $display("FAIL wrap_ptr: got %0d exp 1", bus.sel);
    end
    tick();
  endtask

  task automatic test_idle_drain();
    drive(8'h10, seq_data(32'h4000_0000), 1'b1);
    tick();
    drive(8'h00, '0, 1'b1);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sel !== 3'd5) begin
      errors++; $display("FAIL idle_drain: got ov %b sel %0d exp 0 5", bus.out_valid, bus.sel);
    end
    drive(8'h00, '0, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [255:0] d;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
      drive(8'($urandom_range(0, 255)), d, 1'($urandom_range(0, 3) != 0));
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      drive(8'h00, '0, 1'b1);
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_drain: got %0d words left exp 0", exp_q.size());
    end
  endtask

  initial begin
    bus.req_valid = 8'h00; bus.req_data = '0; bus.out_ready = 1'b0;
    rst = 1'b0;
    m_ptr = 3'd0; m_ov = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_all_requesting();
    test_backpressure();
    test_wrap();
    test_idle_drain();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
